// File: rtl/codec_cfg_sequencer_pkg.sv
// Shared definitions for the codec configuration sequencer: FSM state
// encoding and the codec power-up register table.
package codec_cfg_pkg;

   typedef enum logic [2:0] {
      S_POWERUP,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_READY,
      S_FAIL
   } state_t;

   localparam int NUM_INIT = 9;

   // Power-up register writes, {reg addr, data}, in issue order.
   localparam logic [15:0] INIT_WORD_0 = 16'h0C00;
   localparam logic [15:0] INIT_WORD_1 = 16'h0E03;
   localparam logic [15:0] INIT_WORD_2 = 16'h0017;
   localparam logic [15:0] INIT_WORD_3 = 16'h0217;
   localparam logic [15:0] INIT_WORD_4 = 16'h0470;
   localparam logic [15:0] INIT_WORD_5 = 16'h0670;
   localparam logic [15:0] INIT_WORD_6 = 16'h0A00;
   localparam logic [15:0] INIT_WORD_7 = 16'h0812;
   localparam logic [15:0] INIT_WORD_8 = 16'h1000;

endpackage

// File: rtl/codec_cfg_sequencer_init_rom.sv
// Combinational lookup of the codec init table; unused indices read as zero.
module codec_init_rom
   import codec_cfg_pkg::*;
(
   input  logic [3:0]  index_i,
   output logic [15:0] word_o
);

   // Map the table index onto its register write word.
   always_comb begin
      word_o = 16'h0000;
      case (index_i)
         4'd0:    word_o = INIT_WORD_0;
         4'd1:    word_o = INIT_WORD_1;
         4'd2:    word_o = INIT_WORD_2;
         4'd3:    word_o = INIT_WORD_3;
         4'd4:    word_o = INIT_WORD_4;
         4'd5:    word_o = INIT_WORD_5;
         4'd6:    word_o = INIT_WORD_6;
         4'd7:    word_o = INIT_WORD_7;
         4'd8:    word_o = INIT_WORD_8;
         default: word_o = 16'h0000;
      endcase
   end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Write sequencer and arbiter for the shared codec I2C master: runs the
// power-up register table with timeout/retry, then serves runtime writes.
module codec_cfg_sequencer
   import codec_cfg_pkg::*;
#(
   parameter int POWERUP_CYCLES = 200000,
   parameter int GAP_CYCLES     = 50000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 3
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        reinit,
   input  logic        usr_req,
   input  logic [15:0] usr_word,
   output logic        usr_ack,
   output logic        usr_done,
   output logic        usr_ok,
   output logic        i2c_trig,
   output logic [15:0] i2c_data,
   input  logic        i2c_ackok,
   input  logic        i2c_txdone,
   output logic        init_done,
   output logic        cfg_err,
   output logic        busy
);

   localparam logic [19:0] PWR_LAST    = 20'(POWERUP_CYCLES - 1);
   localparam logic [19:0] GAP_LAST    = 20'(GAP_CYCLES - 1);
   localparam logic [19:0] TO_LAST     = 20'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);
   localparam logic [3:0]  LAST_INDEX  = 4'(NUM_INIT - 1);

   state_t      state_q, state_d;
   logic [19:0] timer_q, timer_d;
   logic [3:0]  index_q, index_d;
   logic [1:0]  retry_q, retry_d;
   logic        txdone_q;
   logic        trig_q, trig_d;
   logic [15:0] data_q, data_d;
   logic [15:0] uword_q, uword_d;
   logic        user_q, user_d;
   logic        ackres_q, ackres_d;
   logic        usr_ack_q, usr_ack_d;
   logic        usr_done_q, usr_done_d;
   logic        usr_ok_q, usr_ok_d;
   logic        init_done_q, init_done_d;
   logic        cfg_err_q, cfg_err_d;
   logic        reinit_pend_q, reinit_pend_d;

   logic        done_rise;
   logic        start_init;
   logic [2:0]  retry_next;
   logic [15:0] rom_word;

   codec_init_rom u_rom (
      .index_i (index_q),
      .word_o  (rom_word)
   );

   assign done_rise  = i2c_txdone & ~txdone_q;
   assign start_init = reinit | reinit_pend_q;
   assign retry_next = {1'b0, retry_q} + 3'd1;

   // Next-state and output decode; every register holds unless a state acts on it.
   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      retry_d       = retry_q;
      trig_d        = trig_q;
      data_d        = data_q;
      uword_d       = uword_q;
      user_d        = user_q;
      ackres_d      = ackres_q;
      usr_ack_d     = 1'b0;
      usr_done_d    = 1'b0;
      usr_ok_d      = 1'b0;
      init_done_d   = init_done_q;
      cfg_err_d     = cfg_err_q;
      reinit_pend_d = reinit_pend_q;

      case (state_q)
         S_POWERUP: begin
            if (timer_q == PWR_LAST) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            data_d  = user_q ? uword_q : rom_word;
            trig_d  = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done_rise) begin
               trig_d   = 1'b0;
               ackres_d = i2c_ackok;
               state_d  = S_GAP;
            end else if (timer_q == TO_LAST) begin
               trig_d   = 1'b0;
               ackres_d = 1'b0;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (timer_q == GAP_LAST) begin
               if (user_q) begin
                  usr_done_d = 1'b1;
                  usr_ok_d   = ackres_q;
                  user_d     = 1'b0;
                  state_d    = S_READY;
               end else if (ackres_q) begin
                  retry_d = 2'd0;
                  index_d = index_q + 4'd1;
                  if (index_q == LAST_INDEX) begin
                     init_done_d = 1'b1;
                     state_d     = S_READY;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end else if (retry_next < RETRY_LIMIT) begin
                  retry_d = retry_next[1:0];
                  state_d = S_ISSUE;
               end else begin
                  cfg_err_d = 1'b1;
                  state_d   = S_FAIL;
               end
            end
         end
         S_READY, S_FAIL: begin
            if (start_init) begin
               init_done_d   = 1'b0;
               cfg_err_d     = 1'b0;
               index_d       = 4'd0;
               retry_d       = 2'd0;
               user_d        = 1'b0;
               reinit_pend_d = 1'b0;
               state_d       = S_ISSUE;
            end else if (state_q == S_READY && usr_req && init_done_q) begin
               uword_d   = usr_word;
               user_d    = 1'b1;
               usr_ack_d = 1'b1;
               state_d   = S_ISSUE;
            end
         end
         default: state_d = S_POWERUP;
      endcase

      if (reinit && (state_q inside {S_ISSUE, S_WAIT, S_GAP})) reinit_pend_d = 1'b1;

      timer_d = (state_d != state_q) ? 20'd0 : timer_q + 20'd1;
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_POWERUP;
         timer_q       <= 20'd0;
         index_q       <= 4'd0;
         retry_q       <= 2'd0;
         txdone_q      <= 1'b1;
         trig_q        <= 1'b0;
         data_q        <= 16'h0000;
         uword_q       <= 16'h0000;
         user_q        <= 1'b0;
         ackres_q      <= 1'b0;
         usr_ack_q     <= 1'b0;
         usr_done_q    <= 1'b0;
         usr_ok_q      <= 1'b0;
         init_done_q   <= 1'b0;
         cfg_err_q     <= 1'b0;
         reinit_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         index_q       <= index_d;
         retry_q       <= retry_d;
         txdone_q      <= i2c_txdone;
         trig_q        <= trig_d;
         data_q        <= data_d;
         uword_q       <= uword_d;
         user_q        <= user_d;
         ackres_q      <= ackres_d;
         usr_ack_q     <= usr_ack_d;
         usr_done_q    <= usr_done_d;
         usr_ok_q      <= usr_ok_d;
         init_done_q   <= init_done_d;
         cfg_err_q     <= cfg_err_d;
         reinit_pend_q <= reinit_pend_d;
      end
   end

   assign i2c_trig  = trig_q;
   assign i2c_data  = data_q;
   assign usr_ack   = usr_ack_q;
   assign usr_done  = usr_done_q;
   assign usr_ok    = usr_ok_q;
   assign init_done = init_done_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = !(state_q inside {S_READY, S_FAIL});

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Self-checking bench for codec_cfg_sequencer with a behavioural I2C master
// model and shortened timing parameters.
module tb_codec_cfg_sequencer;

   localparam int P          = 20;
   localparam int G          = 10;
   localparam int T          = 50;
   localparam int MAXR       = 3;
   localparam int DONE_DELAY = 5;
   localparam int BOUND      = 20000;

   logic        clk = 1'b0;
   logic        reset;
   logic        reinit;
   logic        usr_req;
   logic [15:0] usr_word;
   logic        usr_ack;
   logic        usr_done;
   logic        usr_ok;
   logic        i2c_trig;
   logic [15:0] i2c_data;
   logic        i2c_ackok  = 1'b0;
   logic        i2c_txdone = 1'b0;
   logic        init_done;
   logic        cfg_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // model policy
   logic [15:0] nackWord   = 16'hFFFF;
   int          nackLeft   = 0;
   logic [15:0] noDoneWord = 16'hFFFF;

   logic [15:0] issued[$];
   logic [15:0] expInit[9];
   int          ackCount   = 0;
   int          curLen     = 0;
   int          lastTrigLen = 0;

   codec_cfg_sequencer #(
      .POWERUP_CYCLES (P),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (T),
      .MAX_RETRY      (MAXR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .reinit     (reinit),
      .usr_req    (usr_req),
      .usr_word   (usr_word),
      .usr_ack    (usr_ack),
      .usr_done   (usr_done),
      .usr_ok     (usr_ok),
      .i2c_trig   (i2c_trig),
      .i2c_data   (i2c_data),
      .i2c_ackok  (i2c_ackok),
      .i2c_txdone (i2c_txdone),
      .init_done  (init_done),
      .cfg_err    (cfg_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural I2C master: logs each trig rise, raises txdone after a
   // fixed delay with the policy's ack result, and clears when trig drops.
   logic armed = 1'b1;
   int   modelCnt = 0;
   logic modelAck = 1'b1;
   logic [15:0] modelWord = 16'h0000;
   always @(negedge clk) begin
      if (i2c_trig !== 1'b1) begin
         i2c_txdone = 1'b0;
         armed      = 1'b1;
         modelCnt   = 0;
      end else begin
         if (armed) begin
            armed     = 1'b0;
            modelCnt  = 0;
            modelWord = i2c_data;
            issued.push_back(i2c_data);
            modelAck  = !(i2c_data == nackWord && nackLeft != 0);
            if (!modelAck && nackLeft > 0) nackLeft--;
         end
         modelCnt++;
         if (modelCnt == DONE_DELAY && modelWord != noDoneWord) begin
            i2c_ackok  = modelAck;
            i2c_txdone = 1'b1;
         end
      end
   end

   // Count usr_ack pulses and measure how long each trig assertion lasts.
   always @(negedge clk) begin
      if (usr_ack === 1'b1) ackCount++;
      if (i2c_trig === 1'b1) curLen++;
      else if (curLen > 0) begin
         lastTrigLen = curLen;
         curLen = 0;
      end
   end

   typedef struct {
      string       name;
      logic [15:0] nackWord;
      int          nackLeft;
      logic [15:0] noDoneWord;
      int          expWrites;
      logic [15:0] expLast;
      int          expTargetCnt;
      logic        expInitDone;
      logic        expCfgErr;
      logic        checkOrder;
   } initVec_t;

   initVec_t vecs[4];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic int countWord(input logic [15:0] w);
      int n = 0;
      foreach (issued[i]) if (issued[i] == w) n++;
      return n;
   endfunction

   task automatic checkResetValues(input string prefix);
      checkOutput({prefix, "_trig"},      {31'd0, i2c_trig},  0);
      checkOutput({prefix, "_data"},      {16'd0, i2c_data},  0);
      checkOutput({prefix, "_usr_ack"},   {31'd0, usr_ack},   0);
      checkOutput({prefix, "_usr_done"},  {31'd0, usr_done},  0);
      checkOutput({prefix, "_usr_ok"},    {31'd0, usr_ok},    0);
      checkOutput({prefix, "_init_done"}, {31'd0, init_done}, 0);
      checkOutput({prefix, "_cfg_err"},   {31'd0, cfg_err},   0);
      checkOutput({prefix, "_busy"},      {31'd0, busy},      1);
   endtask

   // Reset the DUT with a given model policy and an empty write log.
   task automatic applyStimulus(input logic [15:0] nw, input int nl, input logic [15:0] nd);
      @(negedge clk);
      reset      = 1'b0;
      nackWord   = nw;
      nackLeft   = nl;
      noDoneWord = nd;
      repeat (3) @(negedge clk);
      issued.delete();
      reset = 1'b1;
   endtask

   task automatic waitIdle(input string name);
      logic found = 1'b0;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput({name, "_idle_reached"}, {31'd0, found}, 1);
   endtask

   task automatic waitUsrDone(input string name, output logic ok);
      logic found = 1'b0;
      ok = 1'bx;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk);
         if (usr_done === 1'b1) begin
            found = 1'b1;
            ok = usr_ok;
            break;
         end
      end
      checkOutput({name, "_done_seen"}, {31'd0, found}, 1);
   endtask

   initial begin
      logic ok;
      logic found;
      logic initAtAck;
      int   n;
      int   base;

      expInit = '{16'h0C00, 16'h0E03, 16'h0017, 16'h0217, 16'h0470,
                  16'h0670, 16'h0A00, 16'h0812, 16'h1000};

      vecs[0] = '{"all_ack",    16'h0C00, 0,  16'hFFFF, 9,  16'h1000, 1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{"nack_0e03",  16'h0E03, 2,  16'hFFFF, 11, 16'h1000, 3, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{"fail_0017",  16'h0017, -1, 16'hFFFF, 5,  16'h0017, 3, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{"timeout_w0", 16'h0C00, 0,  16'h0C00, 3,  16'h0C00, 3, 1'b0, 1'b1, 1'b0};

      reset    = 1'b0;
      reinit   = 1'b0;
      usr_req  = 1'b0;
      usr_word = 16'h0000;

      // reset values and power-up latency
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      found = 1'b0;
      for (int c = 1; c <= P + 10; c++) begin
         @(posedge clk);
         #1;
         if (i2c_trig === 1'b1) begin
            n = c;
            found = 1'b1;
            break;
         end
      end
      checkOutput("powerup_trig_seen", {31'd0, found}, 1);
      checkOutput("powerup_latency", n, P + 1);
      checkOutput("powerup_first_word", {16'd0, i2c_data}, 32'h0C00);

      // table-driven init scenarios
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].nackWord, vecs[v].nackLeft, vecs[v].noDoneWord);
         waitIdle(vecs[v].name);
         checkOutput({vecs[v].name, "_writes"}, issued.size(), vecs[v].expWrites);
         if (issued.size() > 0) begin
            checkOutput({vecs[v].name, "_first"}, {16'd0, issued[0]}, 32'h0C00);
            checkOutput({vecs[v].name, "_last"}, {16'd0, issued[issued.size()-1]}, {16'd0, vecs[v].expLast});
         end
         checkOutput({vecs[v].name, "_target_cnt"}, countWord(vecs[v].nackWord), vecs[v].expTargetCnt);
         checkOutput({vecs[v].name, "_init_done"}, {31'd0, init_done}, {31'd0, vecs[v].expInitDone});
         checkOutput({vecs[v].name, "_cfg_err"}, {31'd0, cfg_err}, {31'd0, vecs[v].expCfgErr});
         checkOutput({vecs[v].name, "_busy"}, {31'd0, busy}, 0);
         if (vecs[v].checkOrder && issued.size() == 9)
            for (int i = 0; i < 9; i++)
               checkOutput($sformatf("%s_order%0d", vecs[v].name, i), {16'd0, issued[i]}, {16'd0, expInit[i]});
      end

      // timeout trig width from the last (never-done) scenario
      checkOutput("timeout_trig_len", lastTrigLen, T);

      // S_FAIL never acks a user request
      base = ackCount;
      @(negedge clk);
      usr_word = 16'h0479;
      usr_req  = 1'b1;
      repeat (100) @(negedge clk);
      usr_req  = 1'b0;
      checkOutput("fail_no_ack", ackCount - base, 0);
      checkOutput("fail_busy", {31'd0, busy}, 0);

      // reinit leaves S_FAIL and reruns the table from 0C00
      nackLeft   = 0;
      noDoneWord = 16'hFFFF;
      issued.delete();
      @(negedge clk);
      reinit = 1'b1;
      @(negedge clk);
      reinit = 1'b0;
      checkOutput("reinit_clears_err", {31'd0, cfg_err}, 0);
      waitIdle("reinit_from_fail");
      checkOutput("reinit_writes", issued.size(), 9);
      if (issued.size() > 0) checkOutput("reinit_first", {16'd0, issued[0]}, 32'h0C00);
      checkOutput("reinit_init_done", {31'd0, init_done}, 1);
      checkOutput("reinit_cfg_err", {31'd0, cfg_err}, 0);

      // runtime write, ACKed
      issued.delete();
      base = ackCount;
      @(negedge clk);
      usr_word = 16'h0479;
      usr_req  = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("usr_ack_pulse", {31'd0, usr_ack}, 1);
      @(negedge clk);
      usr_req = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("usr_ack_one_cycle", {31'd0, usr_ack}, 0);
      checkOutput("usr_trig", {31'd0, i2c_trig}, 1);
      checkOutput("usr_data", {16'd0, i2c_data}, 32'h0479);
      waitUsrDone("usr_ack_write", ok);
      checkOutput("usr_ok_ack", {31'd0, ok}, 1);
      checkOutput("usr_ack_count", ackCount - base, 1);

      // runtime write, NACKed, no retry
      issued.delete();
      nackWord = 16'h0479;
      nackLeft = -1;
      @(negedge clk);
      usr_req = 1'b1;
      @(negedge clk);
      usr_req = 1'b0;
      waitUsrDone("usr_nack_write", ok);
      checkOutput("usr_ok_nack", {31'd0, ok}, 0);
      repeat (G + 10) @(negedge clk);
      checkOutput("usr_nack_no_retry", countWord(16'h0479), 1);

      // reinit and usr_req together: init runs first, then the user word
      nackLeft = 0;
      issued.delete();
      @(negedge clk);
      reinit   = 1'b1;
      usr_req  = 1'b1;
      @(negedge clk);
      reinit   = 1'b0;
      found = 1'b0;
      initAtAck = 1'b0;
      for (int c = 0; c < BOUND; c++) begin
         if (usr_ack === 1'b1) begin
            found = 1'b1;
            initAtAck = init_done;
            break;
         end
         @(negedge clk);
      end
      usr_req = 1'b0;
      checkOutput("prio_ack_seen", {31'd0, found}, 1);
      checkOutput("prio_init_done_at_ack", {31'd0, initAtAck}, 1);
      waitUsrDone("prio_write", ok);
      checkOutput("prio_usr_ok", {31'd0, ok}, 1);
      checkOutput("prio_writes", issued.size(), 10);
      if (issued.size() == 10) begin
         checkOutput("prio_first", {16'd0, issued[0]}, 32'h0C00);
         checkOutput("prio_ninth", {16'd0, issued[8]}, 32'h1000);
         checkOutput("prio_user", {16'd0, issued[9]}, 32'h0479);
      end

      // reset in the middle of S_WAIT
      @(negedge clk);
      reinit = 1'b1;
      @(negedge clk);
      reinit = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (i2c_trig === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("midwait_trig_seen", {31'd0, found}, 1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkResetValues("midwait_reset");
      @(negedge clk);
      issued.delete();
      reset = 1'b1;
      waitIdle("after_midwait");
      checkOutput("after_midwait_writes", issued.size(), 9);
      if (issued.size() > 0) checkOutput("after_midwait_first", {16'd0, issued[0]}, 32'h0C00);
      checkOutput("after_midwait_init_done", {31'd0, init_done}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
Table-driven write sequencer and arbiter for the shared codec I2C master. It runs the codec power-up register sequence with timeout and retry, then grants the same I2C master to runtime register-write requests, for example volume or sample-rate changes. Sits between the top level and i2c_master, driving its trig and 16-bit data inputs.

Parameters:
POWERUP_CYCLES, 200000, clk cycles from reset release to first write
GAP_CYCLES, 50000, idle cycles after every transaction (pass or fail)
TIMEOUT_CYCLES, 1000000, cycles waiting for i2c_txdone rise before declaring timeout
MAX_RETRY, 3, attempts per init word before fail

Ports:
clk  in  1  system clock (50 MHz); one clock domain
reset  in  1  synchronous, active-low
reinit  in  1  1-cycle pulse: rerun init table
usr_req  in  1  runtime write request, level, held until usr_ack
usr_word  in  16  {reg addr[15:8], data[7:0]}, stable while usr_req=1
usr_ack  out  1  1-cycle pulse: request accepted
usr_done  out  1  1-cycle pulse: runtime write finished
usr_ok  out  1  valid with usr_done: 1=ACKed, 0=NACK/timeout
i2c_trig  out  1  to i2c_master trig
i2c_data  out  16  to i2c_master d15..d0
i2c_ackok  in  1  from i2c_master ackOK, sampled on txdone rise
i2c_txdone  in  1  from i2c_master txdone, level
init_done  out  1  high once all init words ACKed; cleared by reinit
cfg_err  out  1  sticky: init word failed MAX_RETRY times
busy  out  1  high in any state except S_READY and S_FAIL

Behaviour:
- Reset (reset=0 at a clk edge): state S_POWERUP, all counters 0, index 0; i2c_trig=0, i2c_data=0, usr_ack=0, usr_done=0, usr_ok=0, init_done=0, cfg_err=0; txdone_q=1, so an already-high txdone is not an edge.
- Edge detect: done_rise = i2c_txdone & ~txdone_q, with txdone_q registered every cycle.
- S_POWERUP: count POWERUP_CYCLES, then go to S_ISSUE. Ignores done_rise and usr_req.
- S_ISSUE: latch i2c_data = source word (init table[index] or latched user word). Raise i2c_trig. Clear timeout counter. Next cycle enter S_WAIT.
- S_WAIT: i2c_trig and i2c_data held constant.
  - On done_rise: drop i2c_trig the following cycle and sample i2c_ackok.
  - If timeout counter reaches TIMEOUT_CYCLES-1 first: treat as NACK and drop i2c_trig.
  - Then enter S_GAP.
- S_GAP: count GAP_CYCLES, then resolve the result.
  - Init word ACKed: index+1, retry=0. If index was NUM_INIT-1, set init_done=1 and go to S_READY; else go to S_ISSUE.
  - Init word NACKed: retry+1. If retry+1 < MAX_RETRY, go to S_ISSUE with the same word. Else set cfg_err=1 and go to S_FAIL.
  - User word: pulse usr_done with usr_ok=ack and go to S_READY. No retry for user words.
- S_READY:
  - reinit has priority over usr_req. It clears init_done and cfg_err, sets index=0 and retry=0, and goes to S_ISSUE with no power-up delay.
  - Else usr_req=1: latch usr_word, pulse usr_ack for 1 cycle, go to S_ISSUE.
  - usr_ack never pulses while init_done=0.
- S_FAIL: i2c_trig=0. Only reinit or reset leaves it; usr_req is never acked.
- reinit outside S_READY/S_FAIL: latched as pending and serviced at the next S_READY entry, ahead of usr_req. A pulse during S_POWERUP is dropped.
- A user write in flight always completes; its usr_done is emitted before the reinit starts.
- Reset mid-transaction: i2c_trig=0 on the next edge. A txdone from the aborted transfer lands in S_POWERUP and is ignored.
- Init table, NUM_INIT=9, in order: 0C00, 0E03, 0017, 0217, 0470, 0670, 0A00, 0812, 1000.
- Widths: timer is 20 bits, shared by power-up, gap and timeout and cleared on every state change. Index is 4 bits; retry is 2 bits.

Decomposition:
- Package codec_cfg_pkg: state encoding (S_POWERUP, S_ISSUE, S_WAIT, S_GAP, S_READY, S_FAIL), NUM_INIT, and the 9 init-word constants.
- Sub-module codec_init_rom: combinational 4-bit index to 16-bit word from the package constants; indices 9-15 return 0000.

Test Plan:
- Model ACKs all, txdone rises 300 cycles after trig -> 9 writes in table order, i2c_data 0C00 first and 1000 last; init_done=1 about 200000 + 9*(300+50000+3) cycles after reset; cfg_err=0.
- Model NACKs word 0E03 twice, then ACKs -> 0E03 issued 3 times, sequence continues, init_done=1, cfg_err=0.
- Model always NACKs 0017 -> exactly 3 attempts of 0017, cfg_err=1, busy=0, usr_req=1 with 0x0479 never acked; then a reinit pulse -> restarts at 0C00.
- txdone never rises on word 0 -> i2c_trig drops after TIMEOUT_CYCLES; retried 3 times, then S_FAIL.
- After init, usr_req with usr_word=0x0479 -> usr_ack one cycle later, i2c_data=0479; usr_done with usr_ok=1 after the gap. Repeat with a NACK -> usr_ok=0.
- reinit and usr_req asserted the same cycle in S_READY -> init rerun first (0C00); user word 0479 issued after init_done. reset=0 mid-S_WAIT -> i2c_trig=0 next edge, all outputs at reset values.
